// File: rtl/instruction_mem_loader.sv
// rtl/instruction_mem_loader.sv - streams a length-prefixed, XOR-checksummed program into instruction memory
// Holds the CPU fetch stage until a load completes with a matching checksum.
module instruction_mem_loader (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state, next_state;
  logic [15:0] word_count;
  logic [11:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] assembly;
  logic [7:0]  checksum;
  logic [15:0] hdr_count;
  logic        last_word;
  logic        start_ok;

  assign hdr_count = {word_count[15:8], byte_data};
  assign last_word = ({4'd0, word_idx} + 16'd1) == word_count;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE: if (start) next_state = S_HDR0;
      S_HDR0: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) next_state = S_HDR1;
      end
      S_HDR1: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid)
          next_state = (hdr_count == 16'd0 || hdr_count > 16'd4096) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid && byte_cnt == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        imem_we    = 1'b1;
        busy       = 1'b1;
        next_state = last_word ? S_CHK : S_DATA;
      end
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) next_state = (byte_data == checksum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) next_state = S_HDR0;
      end
      S_ERR: begin
        err = 1'b1;
        if (start) next_state = S_HDR0;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_count <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      assembly   <= '0;
      checksum   <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else if (start_ok) begin
      word_count <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      assembly   <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        S_HDR0: if (byte_valid) word_count[15:8] <= byte_data;
        S_HDR1: if (byte_valid) word_count[7:0]  <= byte_data;
        S_DATA: if (byte_valid) begin
          assembly <= {assembly[23:0], byte_data};
          checksum <= checksum ^ byte_data;
          byte_cnt <= byte_cnt + 2'd1;
          // Address and data are captured here so they stay stable after the write strobe drops.
          if (byte_cnt == 2'd3) begin
            imem_wdata <= {assembly[23:0], byte_data};
            imem_addr  <= {18'd0, word_idx, 2'b00};
          end
        end
        S_WRITE: if (!last_word) word_idx <= word_idx + 12'd1;
        default: ;
      endcase
    end
  end

endmodule
